// File: rtl/burst_accumulator_if.sv
// Handshake bundle for burst_accumulator: the sample stream in, the burst result out,
// the clear request and the sample count. master is the environment side, slave is the accumulator.
interface burst_accumulator_if #(
    parameter int N  = 8,
    parameter int CW = 3
);
    logic          clear;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_ovf;
    logic [CW-1:0] count;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, count
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, count
    );
endinterface

// File: rtl/burst_accumulator.sv
// Burst accumulator: sums LEN unsigned samples through a conditional-sum adder and
// holds the total, with a sticky carry flag, until the consumer takes it.
module CSA #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);
    localparam int L = (N > 1) ? $clog2(N) : 0;

    // Each level keeps two candidate sums per bit (carry-in 0 / 1) and two candidate
    // carries per block; block size doubles per level until one block spans N bits.
    genvar gl, gi;
    generate
        for (gl = 0; gl <= L; gl++) begin : lvl
            localparam int NB = (N + (1 << gl) - 1) >> gl;
            logic [N-1:0]  s0, s1;
            logic [NB-1:0] c0, c1;

            if (gl == 0) begin : g_leaf
                for (gi = 0; gi < N; gi++) begin : g_bit
                    assign s0[gi] = a[gi] ^ b[gi];
                    assign s1[gi] = ~(a[gi] ^ b[gi]);
                    assign c0[gi] = a[gi] & b[gi];
                    assign c1[gi] = a[gi] | b[gi];
                end
            end else begin : g_merge
                localparam int B = 1 << (gl - 1);
                for (gi = 0; gi < N; gi++) begin : g_bit
                    if (((gi / B) % 2) == 1) begin : g_upper
                        assign s0[gi] = lvl[gl-1].c0[(gi / B) - 1] ? lvl[gl-1].s1[gi] : lvl[gl-1].s0[gi];
                        assign s1[gi] = lvl[gl-1].c1[(gi / B) - 1] ? lvl[gl-1].s1[gi] : lvl[gl-1].s0[gi];
                    end else begin : g_lower
                        assign s0[gi] = lvl[gl-1].s0[gi];
                        assign s1[gi] = lvl[gl-1].s1[gi];
                    end
                end
                for (gi = 0; gi < NB; gi++) begin : g_blk
                    if (((2 * gi + 1) * B) < N) begin : g_pair
                        assign c0[gi] = lvl[gl-1].c0[2*gi] ? lvl[gl-1].c1[2*gi+1] : lvl[gl-1].c0[2*gi+1];
                        assign c1[gi] = lvl[gl-1].c1[2*gi] ? lvl[gl-1].c1[2*gi+1] : lvl[gl-1].c0[2*gi+1];
                    end else begin : g_single
                        assign c0[gi] = lvl[gl-1].c0[2*gi];
                        assign c1[gi] = lvl[gl-1].c1[2*gi];
                    end
                end
            end
        end
    endgenerate

    assign sum = ci ? lvl[L].s1 : lvl[L].s0;
    assign co  = ci ? lvl[L].c1[0] : lvl[L].c0[0];
endmodule

module burst_accumulator #(
    parameter int N   = 8,
    parameter int LEN = 4,
    parameter int CW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    burst_accumulator_if.slave bus
);
    typedef enum logic {ACC, HOLD} state_t;

    state_t        state_reg;
    logic [N-1:0]  acc_reg;
    logic          ovf_reg;
    logic [CW-1:0] count_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic [N-1:0]  csa_sum;
    logic          csa_co;

    CSA #(.N(N)) u_csa (
        .a   (acc_reg),
        .b   (bus.in_data),
        .ci  (1'b0),
        .sum (csa_sum),
        .co  (csa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (bus.in_valid) begin
                        acc_reg   <= csa_sum;
                        ovf_reg   <= ovf_reg | csa_co;
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == CW'(LEN - 1)) begin
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_reg     <= ACC;
                        acc_reg       <= '0;
                        ovf_reg       <= 1'b0;
                        count_reg     <= '0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ACC;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = acc_reg;
    assign bus.out_ovf   = ovf_reg;
    assign bus.count     = count_reg;
endmodule

// File: tb/tb_burst_accumulator.sv
// Bench for burst_accumulator: directed bursts followed by random traffic, every cycle
// compared against a model that tracks the burst as a plain integer total.
module tb_burst_accumulator;
    localparam int N   = 8;
    localparam int LEN = 4;
    localparam int CW  = 3;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    // Model: integer running total of accepted samples and protocol position.
    int   m_total;
    int   m_count;
    bit   m_hold;

    burst_accumulator_if #(.N(N), .CW(CW)) bus ();

    burst_accumulator #(.N(N), .LEN(LEN), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_total = 0;
        m_count = 0;
        m_hold  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check all outputs.
    task automatic cycle(input bit rst, input bit clr, input bit v,
                         input logic [N-1:0] d, input bit ordy);
        rst_n        = ~rst;
        bus.clear    = clr;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.out_ready = ordy;
        @(posedge clk);
        if (rst || clr) begin
            model_clear();
        end else if (!m_hold) begin
            if (v) begin
                m_total += int'(d);
                m_count++;
                if (m_count == LEN) m_hold = 1'b1;
            end
        end else if (ordy) begin
            $display("[TB] burst taken sum=%0d ovf=%0d", m_total % (1 << N), m_total >= (1 << N));
            model_clear();
        end
        #1;
        check("in_ready",  32'(bus.in_ready),  32'(!m_hold));
        check("out_valid", 32'(bus.out_valid), 32'(m_hold));
        check("count",     32'(bus.count),     32'(m_count));
        check("out_sum",   32'(bus.out_sum),   32'(m_total % (1 << N)));
        check("out_ovf",   32'(bus.out_ovf),   32'(m_total >= (1 << N)));
    endtask

    task automatic burst(input int a, input int b, input int c, input int d, input bit ordy);
        cycle(0, 0, 1, N'(a), ordy);
        cycle(0, 0, 1, N'(b), ordy);
        cycle(0, 0, 1, N'(c), ordy);
        cycle(0, 0, 1, N'(d), ordy);
    endtask

    initial begin
        logic [N-1:0] held_sum;
        tests_run    = 0;
        tests_failed = 0;
        model_clear();
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 1, 8'd77, 1);

        // Basic burst with immediate take.
        burst(10, 20, 30, 40, 1);
        check("basic_sum", 32'(bus.out_sum), 32'd100);
        cycle(0, 0, 1, 8'd99, 1);
        check("basic_back_to_acc", 32'(bus.in_ready), 32'd1);

        // Overflow, then a clean burst showing the flag does not carry over.
        burst(100, 100, 50, 10, 0);
        check("ovf_sum", 32'(bus.out_sum), 32'd4);
        check("ovf_flag", 32'(bus.out_ovf), 32'd1);
        cycle(0, 0, 0, '0, 1);
        burst(1, 1, 1, 1, 0);
        check("clean_ovf", 32'(bus.out_ovf), 32'd0);
        cycle(0, 0, 0, '0, 1);

        // Backpressure with ignored in_valid pulses.
        burst(255, 255, 255, 255, 0);
        held_sum = bus.out_sum;
        for (int i = 0; i < 5; i++) cycle(0, 0, i[0], 8'h33, 0);
        check("bp_sum", 32'(bus.out_sum), 32'hFC);
        check("bp_stable", 32'(bus.out_sum), 32'(held_sum));
        cycle(0, 0, 0, '0, 1);

        // Gapped input.
        cycle(0, 0, 1, 8'd5, 0);
        cycle(0, 0, 0, 8'd50, 0);
        cycle(0, 0, 0, 8'd51, 0);
        cycle(0, 0, 1, 8'd6, 0);
        cycle(0, 0, 0, 8'd52, 0);
        cycle(0, 0, 1, 8'd7, 0);
        cycle(0, 0, 1, 8'd8, 0);
        check("gap_sum", 32'(bus.out_sum), 32'd26);
        cycle(0, 0, 0, '0, 1);

        // clear drops partial sum and the coincident sample.
        cycle(0, 0, 1, 8'd3, 0);
        cycle(0, 0, 1, 8'd4, 0);
        cycle(0, 1, 1, 8'd9, 0);
        burst(1, 2, 3, 4, 0);
        check("clear_sum", 32'(bus.out_sum), 32'd10);

        // Reset while holding a result.
        cycle(1, 0, 0, '0, 0);
        burst(2, 2, 2, 2, 1);
        check("rst_sum", 32'(bus.out_sum), 32'd8);

        // Random traffic including extremes, clears, resets and backpressure.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [N-1:0] d;
            r = int'($urandom_range(0, 3));
            d = (r == 0) ? '0 : (r == 1) ? '1 : N'($urandom);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/burst_accumulator.md
# burst_accumulator

Sequential accumulator that sits directly downstream of the conditional-sum adder and closes its loop. It accepts a stream of unsigned N-bit samples over a valid/ready handshake and sums exactly LEN of them per burst. The running sum is fed back through one `CSA #(N)` instance, and the sum and carry-out are registered every accepted cycle. The finished burst total, with a sticky overflow flag, is held on a valid/ready output port until the consumer takes it. The block drives the Basys3 lab datapath, for example switches in and LEDs or 7-segment display out.

## Interface
Parameters:
- N, 8: sample and accumulator width in bits; also the width of the embedded `CSA` (≥1).
- LEN, 4: samples per burst (1..2^CW−1).
- CW, 3: width of the sample counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- clear  in  1  synchronous burst abort; discards the partial sum.
- in_valid  in  1  in_data is valid.
- in_data  in  N  unsigned sample.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  burst result is available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  N  burst sum modulo 2^N.
- out_ovf  out  1  at least one adder carry-out occurred during the burst.
- count  out  CW  samples accepted in the current burst.

## Operation
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Adder: `CSA #(N)` with a=acc_reg, b=in_data, ci=1'b0. It is purely combinational; no other adder exists in the block.
- Accept in ACC (in_valid & in_ready):
  - acc_reg ← CSA sum.
  - ovf_reg ← ovf_reg | CSA co.
  - count ← count+1.
- Last accept: when count==LEN−1, the next state is HOLD and count becomes LEN.
- In HOLD:
  - out_sum=acc_reg and out_ovf=ovf_reg, stable until taken.
  - in_data is ignored.
  - On out_ready: acc_reg, ovf_reg and count go to 0, and the state goes to ACC.
- Register updates happen only on an accept or a result-taken event. in_valid with in_ready=0 has no effect.
- Arithmetic: unsigned only; wrap modulo 2^N. out_ovf is sticky for the whole burst, including a carry on the final sample.
- Priority (highest first): rst_n=0, then clear, then handshake events.
  - clear=1 in any state: acc_reg=0, ovf_reg=0, count=0, state=ACC.
  - A sample presented in the same cycle as clear is dropped.
  - A held result is discarded.
- LEN=1: every accepted sample goes straight to HOLD; out_sum=in_data and out_ovf=0.
- in_data values at 0 and at 2^N−1 need no special handling.

## Timing
- Reset values (after any clk edge with rst_n=0): state=ACC, acc_reg=0, ovf_reg=0, count=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
- Reset mid-burst or during HOLD takes effect on that edge and loses the pending result.
- Throughput: one sample per cycle while in ACC.
- Latency: out_valid rises on the edge that accepts sample LEN, so it is visible in the following cycle.
- HOLD lasts at least one cycle. With out_ready held high, the next burst's first accept is possible one cycle after out_valid rises, giving one bubble per burst.
- out_valid, out_sum and out_ovf do not change while out_valid=1 and out_ready=0, except on clear or reset.
- All outputs are registered or decoded from state; there is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Critical path: acc_reg → CSA (log2 N select levels) → acc_reg. It must meet 100 MHz at N≤32 on XC7A35T.

## Test plan
- N=8, LEN=4: feed 10, 20, 30, 40 on consecutive cycles with out_ready=1. Expect out_valid=1 on the cycle after the 4th accept, out_sum=100, out_ovf=0, and in_ready=0 for exactly one cycle.
- Overflow: feed 100, 100, 50, 10. Expect out_sum=4 (260 mod 256) and out_ovf=1. A following burst of 1, 1, 1, 1 gives out_sum=4 and out_ovf=0, showing the sticky flag cleared.
- Backpressure: hold out_ready=0 for 5 cycles after a burst of 0xFF ×4. Expect out_sum=0xFC and out_ovf=1 held constant, in_ready=0, and in_valid pulses ignored. Raising out_ready returns the block to ACC with count=0.
- Gapped input: in_valid pattern 1,0,0,1,0,1,1 with data 5,x,x,6,x,7,8. Expect only the 4 valid samples accepted, count stepping 1,1,1,2,2,3,4, and out_sum=26.
- clear after 2 samples (3, 4), asserted together with in_valid=1 and data 9. Expect count=0, the 9 dropped, and the next burst 1, 2, 3, 4 giving out_sum=10.
- rst_n=0 for one cycle while in HOLD. Expect all outputs at their reset values on the next cycle, and the next burst 2, 2, 2, 2 giving out_sum=8.
